// File: rtl/serial_rx_frame_ctrl.sv
// Frame controller for the UART receiver byte stream: SYNC, LEN, payload, CHK.
// Optional mid-frame idle timeout is enabled by defining SERIAL_RX_FRAME_TIMEOUT_EN.
module serial_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 400
) (
    input  logic       clk_x4,
    input  logic       rst_x,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_error,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [2:0] o_err_code,
    output logic [7:0] o_err_count
);

    typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CHECK} state_t;

    localparam logic [2:0] ERR_FRAMING  = 3'd1;
    localparam logic [2:0] ERR_LEN      = 3'd2;
    localparam logic [2:0] ERR_OVERRUN  = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;
    localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_sum, w_sum_nxt;
    logic [7:0] r_remaining, w_rem_nxt;
    logic [7:0] r_data;
    logic       r_valid, r_last;
    logic       r_frame_ok, r_frame_err;
    logic [2:0] r_err_code, w_err_code;
    logic [7:0] r_err_count;
    logic       w_load, w_ok, w_err;

    // An i_error pulse wins over a simultaneous i_valid.
    wire w_evt    = i_valid | i_error;
    wire w_byte   = i_valid & ~i_error;
    wire w_accept = r_valid & i_ready;

`ifdef SERIAL_RX_FRAME_TIMEOUT_EN
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;
    logic [15:0] r_timer;
    wire w_timeout = (r_state != ST_HUNT) && !w_evt &&
                     (r_timer == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_x4 or negedge rst_x) begin
        if (!rst_x)                           r_timer <= '0;
        else if (r_state == ST_HUNT || w_evt) r_timer <= '0;
        else                                  r_timer <= r_timer + 16'd1;
    end
`endif

    // NOTE: every comb output gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_rem_nxt   = r_remaining;
        w_load      = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_err_code  = r_err_code;
        case (r_state)
            ST_HUNT: begin
                if (w_byte && i_data == SYNC_BYTE) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (i_error) begin
                    w_err = 1'b1; w_err_code = ERR_FRAMING; w_state_nxt = ST_HUNT;
                end else if (w_byte) begin
                    if (i_data == 8'd0 || i_data > MAX_LEN_B) begin
                        w_err = 1'b1; w_err_code = ERR_LEN; w_state_nxt = ST_HUNT;
                    end else begin
                        w_sum_nxt   = i_data;
                        w_rem_nxt   = i_data;
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_error) begin
                    w_err = 1'b1; w_err_code = ERR_FRAMING; w_state_nxt = ST_HUNT;
                end else if (w_byte) begin
                    // A byte still held and not taken this cycle cannot be overwritten.
                    if (r_valid && !i_ready) begin
                        w_err = 1'b1; w_err_code = ERR_OVERRUN; w_state_nxt = ST_HUNT;
                    end else begin
                        w_load    = 1'b1;
                        w_sum_nxt = r_sum + i_data;
                        w_rem_nxt = r_remaining - 8'd1;
                        if (r_remaining == 8'd1) w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (i_error) begin
                    w_err = 1'b1; w_err_code = ERR_FRAMING;
                end else if (w_byte) begin
                    if (i_data == r_sum) w_ok = 1'b1;
                    else begin
                        w_err = 1'b1; w_err_code = ERR_CHECKSUM;
                    end
                end
                if (w_evt) w_state_nxt = ST_HUNT;
            end
            default: w_state_nxt = ST_HUNT;
        endcase
`ifdef SERIAL_RX_FRAME_TIMEOUT_EN
        if (w_timeout) begin
            w_err = 1'b1; w_err_code = ERR_TIMEOUT; w_state_nxt = ST_HUNT;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_x4 or negedge rst_x) begin
        if (!rst_x) begin
            r_state     <= ST_HUNT;
            r_sum       <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sum       <= w_sum_nxt;
            r_remaining <= w_rem_nxt;
            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;
            r_err_code  <= w_err_code;
            if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            if (w_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
                r_last  <= (r_remaining == 8'd1);
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_last      = r_last;
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_err = r_frame_err;
    assign o_err_code  = r_err_code;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_serial_rx_frame_ctrl.sv
// Scoreboard bench for serial_rx_frame_ctrl: directed frames push expectations,
// a negedge monitor pops and compares payload bytes and frame result pulses.
module tb_serial_rx_frame_ctrl;

    typedef struct {
        logic       ok;
        logic [2:0] code;
        logic [7:0] count;
    } ev_t;

    logic       clk_x4 = 1'b0;
    logic       rst_x  = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic       i_valid = 1'b0;
    logic       i_error = 1'b0;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_last, o_frame_ok, o_frame_err;
    logic [2:0] o_err_code;
    logic [7:0] o_err_count;

    ev_t        ev_q[$];
    logic [8:0] pl_q[$];
    logic [7:0] exp_count = 8'd0;
    logic [2:0] exp_code  = 3'd0;
    int         n_total = 0;
    int         n_pass  = 0;

    serial_rx_frame_ctrl dut (
        .clk_x4      (clk_x4),
        .rst_x       (rst_x),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_error     (i_error),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_frame_ok  (o_frame_ok),
        .o_frame_err (o_frame_err),
        .o_err_code  (o_err_code),
        .o_err_count (o_err_count)
    );

    always #5 clk_x4 = ~clk_x4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        i_data = b; i_valid = 1'b1;
        @(posedge clk_x4); #1;
        i_valid = 1'b0;
        repeat (gap) begin @(posedge clk_x4); #1; end
    endtask

    task automatic send_err(input int gap);
        i_error = 1'b1;
        @(posedge clk_x4); #1;
        i_error = 1'b0;
        repeat (gap) begin @(posedge clk_x4); #1; end
    endtask

    task automatic exp_pl(input logic [7:0] d, input logic last);
        pl_q.push_back({last, d});
    endtask

    task automatic exp_err(input logic [2:0] c);
        ev_t e;
        exp_code = c;
        if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
        e.ok = 1'b0; e.code = c; e.count = exp_count;
        ev_q.push_back(e);
    endtask

    task automatic exp_ok();
        ev_t e;
        e.ok = 1'b1; e.code = exp_code; e.count = exp_count;
        ev_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {12'd0, o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_err_code, o_err_count}, 32'd0);
    endtask

    initial begin : monitor
        logic [8:0] p;
        ev_t        e;
        forever begin
            @(negedge clk_x4);
            if (rst_x) begin
                if (o_valid && i_ready) begin
                    if (pl_q.size() == 0) begin
                        n_total++;
                        $display("FAIL payload_extra: got %h, expected no byte", o_data);
                    end else begin
                        p = pl_q.pop_front();
                        check("payload", {23'd0, o_last, o_data}, {23'd0, p});
                    end
                end
                if (o_frame_ok || o_frame_err) begin
                    if (ev_q.size() == 0) begin
                        n_total++;
                        $display("FAIL event_extra: got ok=%b err=%b code=%0d, expected none",
                                 o_frame_ok, o_frame_err, o_err_code);
                    end else begin
                        e = ev_q.pop_front();
                        check("frame_event",
                              {19'd0, o_frame_ok, o_frame_err, o_err_code, o_err_count},
                              {19'd0, e.ok, ~e.ok, e.code, e.count});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        #12;
        check_reset_outputs("reset_state");
        @(posedge clk_x4); #1;
        rst_x = 1'b1;
        @(posedge clk_x4); #1;

        // Good frame: LEN=3, sum 03+11+22+33 = 69.
        exp_pl(8'h11, 1'b0); exp_pl(8'h22, 1'b0); exp_pl(8'h33, 1'b1); exp_ok();
        send_byte(8'hA5, 2); send_byte(8'h03, 2);
        send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2); send_byte(8'h69, 3);

        // Checksum mismatch: 02+10+20 = 32, CHK 00.
        exp_pl(8'h10, 1'b0); exp_pl(8'h20, 1'b1); exp_err(3'd4);
        send_byte(8'hA5, 2); send_byte(8'h02, 2);
        send_byte(8'h10, 2); send_byte(8'h20, 2); send_byte(8'h00, 3);

        // Noise ignored, LEN=0 rejected; then LEN=1 frame, error code stays 2.
        exp_err(3'd2);
        send_byte(8'h7E, 2); send_byte(8'hA5, 2); send_byte(8'h00, 3);
        exp_pl(8'h55, 1'b1); exp_ok();
        send_byte(8'hA5, 2); send_byte(8'h01, 2); send_byte(8'h55, 2); send_byte(8'h56, 3);

        // Back-to-back payload: load coincides with acceptance, 02+AA+BB = 67.
        exp_pl(8'hAA, 1'b0); exp_pl(8'hBB, 1'b1); exp_ok();
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'h67, 3);

        // Overrun: downstream stalled, second payload byte aborts, first byte kept.
        i_ready = 1'b0;
        exp_err(3'd3);
        send_byte(8'hA5, 2); send_byte(8'h02, 2); send_byte(8'h10, 2); send_byte(8'h20, 3);
        check("overrun_hold", {22'd0, o_valid, o_last, o_data}, {22'd0, 1'b1, 1'b0, 8'h10});
        exp_pl(8'h10, 1'b0);
        i_ready = 1'b1;
        repeat (3) begin @(posedge clk_x4); #1; end

        // Framing error mid-payload.
        exp_pl(8'h11, 1'b0); exp_err(3'd1);
        send_byte(8'hA5, 2); send_byte(8'h03, 2); send_byte(8'h11, 2); send_err(3);

        // Simultaneous valid+error on LEN is a framing error.
        exp_err(3'd1);
        send_byte(8'hA5, 2);
        i_error = 1'b1;
        send_byte(8'h02, 0);
        i_error = 1'b0;
        repeat (3) begin @(posedge clk_x4); #1; end

        // i_error in HUNT is ignored; LEN = MAX_LEN+1 rejected.
        send_err(3);
        exp_err(3'd2);
        send_byte(8'hA5, 2); send_byte(8'd17, 3);

        // LEN = MAX_LEN: 16 bytes of 01, sum 10+10 = 20.
        for (int i = 0; i < 16; i++) exp_pl(8'h01, (i == 15));
        exp_ok();
        send_byte(8'hA5, 1); send_byte(8'd16, 1);
        for (int i = 0; i < 16; i++) send_byte(8'h01, 1);
        send_byte(8'h20, 3);

        // 300 bad-LEN frames: count saturates.
        for (int i = 0; i < 300; i++) begin
            exp_err(3'd2);
            send_byte(8'hA5, 1); send_byte(8'h00, 1);
        end
        repeat (2) begin @(posedge clk_x4); #1; end
        check("err_count_saturated", {24'd0, o_err_count}, 32'h0000_00FF);

`ifdef SERIAL_RX_FRAME_TIMEOUT_EN
        // Silence mid-payload: pulse 400 cycles after the last byte.
        exp_pl(8'h11, 1'b0); exp_err(3'd5);
        send_byte(8'hA5, 2); send_byte(8'h02, 2); send_byte(8'h11, 0);
        n = 0;
        while (!o_frame_err && n < 600) begin
            @(posedge clk_x4); #1;
            n++;
        end
        check("timeout_latency", n, 400);
        repeat (3) begin @(posedge clk_x4); #1; end
`endif

        // Asynchronous reset mid-frame.
        exp_pl(8'h11, 1'b0);
        send_byte(8'hA5, 2); send_byte(8'h03, 2); send_byte(8'h11, 3);
        #2 rst_x = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk_x4); #1;
        @(posedge clk_x4); #1;
        rst_x = 1'b1;
        exp_count = 8'd0; exp_code = 3'd0;
        @(posedge clk_x4); #1;

        exp_pl(8'h55, 1'b1); exp_ok();
        send_byte(8'hA5, 2); send_byte(8'h01, 2); send_byte(8'h55, 2); send_byte(8'h56, 3);

        n = 0;
        while ((ev_q.size() != 0 || pl_q.size() != 0) && n < 200) begin
            @(posedge clk_x4); #1;
            n++;
        end
        check("events_drained", ev_q.size(), 0);
        check("payload_drained", pl_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
